// File: rtl/flash_burst_sample_reader.sv
// Streams a flash word-address window to the audio path: Avalon-MM burst reads into a
// word FIFO, unpacked into SAMPLE_W-bit samples on a valid/ready handshake.
module flash_burst_sample_reader #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         dir,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic [ADDR_W-1:0]            end_addr,
  output logic                         flash_mem_read,
  output logic [ADDR_W-1:0]            flash_mem_address,
  output logic [$clog2(BURST_LEN):0]   flash_mem_burstcount,
  input  logic                         flash_mem_waitrequest,
  input  logic [31:0]                  flash_mem_readdata,
  input  logic                         flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         busy,
  output logic                         wrap_pulse,
  output logic [2:0]                   state
);

  localparam int unsigned SPW   = 32 / SAMPLE_W;
  localparam int unsigned K_W   = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BC_W  = $clog2(BURST_LEN) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RECV = 3'd2,
    STOP = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [ADDR_W-1:0]  lo_q, lo_d, hi_q, hi_d, cur_q, cur_d;
  logic               read_q, read_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BC_W-1:0]    bc_q, bc_d, beat_q, beat_d;
  logic               wrap_q, wrap_d;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [K_W-1:0]     k_q;

  logic [ADDR_W:0]    remain;
  logic [BC_W-1:0]    burst_len;
  logic [CNT_W-1:0]   free_slots;
  logic               fifo_wr, fifo_pop, k_last, take;
  logic [K_W-1:0]     lane_idx;
  logic [31:0]        head;
  logic [SAMPLE_W-1:0] lanes [SPW];

  // Forward bursts are clipped so they never run past the window end.
  assign remain     = {1'b0, hi_q} - {1'b0, cur_q} + (ADDR_W+1)'(1);
  assign free_slots = CNT_W'(FIFO_DEPTH) - count_q;

  always_comb begin
    if (dir_q)
      burst_len = BC_W'(1);
    else if (remain < (ADDR_W+1)'(BURST_LEN))
      burst_len = BC_W'(remain);
    else
      burst_len = BC_W'(BURST_LEN);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cur_d   = cur_q;
    read_d  = read_q;
    addr_d  = addr_q;
    bc_d    = bc_q;
    beat_d  = beat_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (start_addr <= end_addr)) begin
          dir_d   = dir;
          lo_d    = start_addr;
          hi_d    = end_addr;
          cur_d   = dir ? end_addr : start_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (read_q) begin
          if (!flash_mem_waitrequest) begin
            read_d  = 1'b0;
            beat_d  = '0;
            state_d = RECV;
            // Wrap is decided against the bound before updating, so 0/max addresses cannot alias.
            if (dir_q) begin
              if (cur_q == lo_q) begin
                cur_d  = hi_q;
                wrap_d = 1'b1;
              end else begin
                cur_d = cur_q - ADDR_W'(1);
              end
            end else begin
              if ((hi_q - cur_q) < ADDR_W'(bc_q)) begin
                cur_d  = lo_q;
                wrap_d = 1'b1;
              end else begin
                cur_d = cur_q + ADDR_W'(bc_q);
              end
            end
          end
        end else if (!start) begin
          state_d = STOP;
        end else if (free_slots >= CNT_W'(burst_len)) begin
          read_d = 1'b1;
          addr_d = cur_q;
          bc_d   = burst_len;
        end
      end
      RECV: begin
        if (flash_mem_readdatavalid) begin
          beat_d = beat_q + BC_W'(1);
          if (beat_q == bc_q - BC_W'(1))
            state_d = start ? REQ : STOP;
        end
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cur_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      bc_q    <= '0;
      beat_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cur_q   <= cur_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      bc_q    <= bc_d;
      beat_q  <= beat_d;
      wrap_q  <= wrap_d;
    end
  end

  assign fifo_wr      = (state_q == RECV) && flash_mem_readdatavalid;
  assign sample_valid = (count_q != '0);
  assign take         = sample_valid && sample_ready;
  assign k_last       = (k_q == K_W'(SPW - 1));
  assign fifo_pop     = take && k_last;

  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr_q] <= flash_mem_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      k_q      <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (fifo_wr && !fifo_pop)
        count_q <= count_q + CNT_W'(1);
      else if (!fifo_wr && fifo_pop)
        count_q <= count_q - CNT_W'(1);
      if (take)
        k_q <= k_last ? '0 : k_q + K_W'(1);
    end
  end

  assign head     = mem[rd_ptr_q];
  assign lane_idx = dir_q ? (K_W'(SPW - 1) - k_q) : k_q;

  always_comb begin
    for (int unsigned i = 0; i < SPW; i++)
      lanes[i] = head[i*SAMPLE_W +: SAMPLE_W];
  end

  assign sample_out           = sample_valid ? lanes[lane_idx] : '0;
  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_burstcount = bc_q;
  assign busy                 = (state_q != IDLE);
  assign wrap_pulse           = wrap_q;
  assign state                = state_q;

endmodule
